bch_encoder_par: RTL and testbench
==================================

Name: bch_encoder_par

Overview:
- Parametrised systematic cyclic (BCH-family) encoder; generalises the fixed 56-bit serial (63,56) encoder.
- Configurable code length N, message length K, generator polynomial and bits-per-cycle W.
- Accepts one K-bit message per transaction over a valid/ready handshake and runs a W-bit-per-cycle LFSR division.
- Returns the N-bit codeword {message, parity} over a valid/ready handshake; sits between the framer and the channel serialiser.

Parameters:
N, 63, codeword length in bits
K, 56, message length in bits; P = N-K parity bits (default 7)
GEN_POLY, 8'hC5, generator polynomial, P+1 bits, bit i = coefficient of x^i (default (x+1)(x^6+x+1) = x^7+x^6+x^2+1)
W, 1, message bits folded into the LFSR per clock; K % W must be 0

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  message present on in_msg
in_ready  output  1  encoder can accept a message
in_msg  input  K  message, bit K-1 is transmitted first (highest-order coefficient)
out_valid  output  1  codeword present on out_cw
out_ready  input  1  downstream accepts codeword
out_cw  output  N  codeword {msg[K-1:0], parity[P-1:0]}
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface decided: one clock clk; reset rst is synchronous and active-high.
- Elaboration checks: GEN_POLY[P]==1, GEN_POLY[0]==1, K%W==0, N>K; on violation, use $error/$fatal.
- Reset (rst=1 at an edge): state=IDLE, in_ready=1, out_valid=0, busy=0, out_cw=0, parity=0, step counter=0. Reset overrides any state, including mid-SHIFT or DONE with an unaccepted codeword; that codeword is discarded.
- FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_msg to msg_reg, clear parity to 0 and the counter to 0, then go to SHIFT.
  - in_msg is sampled only on the accept edge.
- SHIFT:
  - in_ready=0.
  - Each cycle, process W bits, MSB first, starting at msg_reg[K-1-cnt*W].
  - Per bit b, apply f = parity[P-1]^b, then parity = {parity[P-2:0],1'b0} ^ (f ? GEN_POLY[P-1:0] : 0).
  - The W steps are unrolled combinationally within one cycle.
  - The counter increments by 1 per cycle. After cycle K/W-1 completes, go to DONE.
- DONE:
  - out_valid=1 and out_cw={msg_reg, parity}; both are held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE (out_valid=0 and in_ready=1 on the next cycle).
  - Output backpressure of any length must be tolerated without corrupting out_cw.
- Latency: accept edge to out_valid high is K/W cycles (56 at defaults). Minimum period per message is K/W+2 cycles.
- in_valid asserted while in_ready=0 is ignored. No message is accepted in SHIFT or DONE.
- out_ready asserted while out_valid=0 has no effect.
- Resulting parity equals (msg(x)*x^P) mod g(x); every out_cw polynomial is divisible by g(x).
- All arithmetic is GF(2) (XOR only); no counters wrap, since the counter width is clog2(K/W+1).

Test Plan:
- Reset mid-SHIFT: accept msg=56'hFF..F, pulse rst at cycle 20 -> next cycle in_ready=1, out_valid=0, busy=0. A following msg=0 encodes to out_cw=63'h0.
- Unit vectors at defaults: msg=1 -> parity=7'h45 (out_cw=63'h45|1<<7); msg=2 -> parity=7'h4F; msg=3 -> parity=7'h0A (linearity). out_valid rises exactly 56 cycles after the accept edge.
- Pattern msg={24'h555555,32'hDDDDDDDD} at W=1 and W=8 -> identical out_cw, matching the software model. Latency is 56 and 7 cycles respectively.
- Backpressure: hold out_ready=0 for 100 cycles in DONE with in_valid=1 -> out_cw stable, in_ready=0, no second accept. Raise out_ready -> single handshake, then in_ready=1 next cycle.
- Random regression: 10k random messages at defaults and at N=31,K=26,GEN_POLY=6'h25,W=2 -> every out_cw mod g(x)==0 and out_cw[N-1:P]==msg; throughput is one word per K/W+2 cycles with out_ready tied high.

Source files
------------

// File: rtl/bch_encoder_par.sv
// rtl/bch_encoder_par.sv - systematic cyclic (BCH-family) encoder, W message bits folded per clock
module bch_encoder_par #(
    parameter int             N        = 63,
    parameter int             K        = 56,
    parameter logic [N-K:0]   GEN_POLY = 8'hC5,
    parameter int             W        = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] in_msg,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_cw,
    output logic         busy
);

    localparam int P     = N - K;
    localparam int STEPS = K / W;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (N <= K) begin : g_bad_nk
        $error("bch_encoder_par: N must exceed K");
    end
    if (K % W != 0) begin : g_bad_w
        $error("bch_encoder_par: K must be a multiple of W");
    end
    if (GEN_POLY[P] != 1'b1 || GEN_POLY[0] != 1'b1) begin : g_bad_poly
        $error("bch_encoder_par: generator must have x^P and x^0 terms");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state_q;
    logic [K-1:0]    msg_q;
    logic [K-1:0]    sh_q;
    logic [P-1:0]    parity_q;
    logic [P-1:0]    parity_d;
    logic [CW-1:0]   cnt_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [W-1:0]    chunk;

    // sh_q walks the message MSB-first so the next W bits always sit at the top
    assign chunk = sh_q[K-1 -: W];

    always_comb begin
        parity_d = parity_q;
        for (int i = 0; i < W; i++) begin
            parity_d = (parity_d << 1)
                     ^ ({P{parity_d[P-1] ^ chunk[W-1-i]}} & GEN_POLY[P-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            msg_q       <= '0;
            sh_q        <= '0;
            parity_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        msg_q      <= in_msg;
                        sh_q       <= in_msg;
                        parity_q   <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    parity_q <= parity_d;
                    sh_q     <= sh_q << W;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_cw    = {msg_q, parity_q};

endmodule

// File: tb/tb_bch_encoder_par.sv
// tb/tb_bch_encoder_par.sv - directed and streaming checks of bch_encoder_par at three configurations
module tb_bch_encoder_par;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  iv, ordy, irdy, ov, bsy;
    logic [55:0] m0, m1;
    logic [25:0] m2;
    logic [62:0] cw0, cw1;
    logic [30:0] cw2;

    int checks = 0;
    int errors = 0;

    int          n_tab [3] = '{63, 63, 31};
    int          k_tab [3] = '{56, 56, 26};
    int          p_tab [3] = '{7, 7, 5};
    int          steps [3] = '{56, 7, 13};
    logic [63:0] g_tab [3] = '{64'hC5, 64'hC5, 64'h25};

    always #5 clk = ~clk;

    bch_encoder_par u_w1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_msg(m0),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_cw(cw0), .busy(bsy[0])
    );

    bch_encoder_par #(.W(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_msg(m1),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_cw(cw1), .busy(bsy[1])
    );

    bch_encoder_par #(.N(31), .K(26), .GEN_POLY(6'h25), .W(2)) u_s (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_msg(m2),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_cw(cw2), .busy(bsy[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setmsg(input int s, input logic [63:0] v);
        case (s)
            0:       m0 = v[55:0];
            1:       m1 = v[55:0];
            default: m2 = v[25:0];
        endcase
    endtask

    function automatic logic [63:0] cw_of(input int s);
        case (s)
            0:       return 64'(cw0);
            1:       return 64'(cw1);
            default: return 64'(cw2);
        endcase
    endfunction

    // long-division remainder of v(x) by g(x)
    function automatic logic [63:0] poly_mod(input logic [63:0] v, input int s);
        for (int i = n_tab[s] - 1; i >= p_tab[s]; i--)
            if (v[i]) v = v ^ (g_tab[s] << (i - p_tab[s]));
        return v;
    endfunction

    function automatic logic [63:0] exp_cw(input int s, input logic [63:0] msg);
        logic [63:0] sh;
        sh = msg << p_tab[s];
        return sh | poly_mod(sh, s);
    endfunction

    function automatic logic [63:0] rnd(input int s);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r & ((64'd1 << k_tab[s]) - 64'd1);
    endfunction

    task automatic encode(input int s, input logic [63:0] v, output logic [63:0] cw, output int lat);
        int n = 0;
        setmsg(s, v);
        iv[s] = 1'b1;
        while (!irdy[s] && n < 300) begin tick(); n++; end
        if (!irdy[s]) check("accept_timeout", 64'd0, 64'd1);
        tick();
        iv[s] = 1'b0;
        lat = 0;
        while (!ov[s] && lat < 300) begin tick(); lat++; end
        cw = cw_of(s);
        ordy[s] = 1'b1;
        tick();
        ordy[s] = 1'b0;
    endtask

    task automatic stream(input int s, input int cnt);
        logic [63:0] q[$];
        logic [63:0] cur, e, pc;
        logic        pr, pv;
        int cyc = 0, sent = 0, got = 0, last = 0;
        ordy[s] = 1'b1;
        cur = rnd(s);
        setmsg(s, cur);
        iv[s] = 1'b1;
        while (got < cnt && cyc < cnt * (steps[s] + 2) + 50) begin
            pr = irdy[s];
            pv = ov[s];
            pc = cw_of(s);
            if (pv) begin
                e = (q.size() > 0) ? q.pop_front() : 64'hX;
                check("rnd_cw", pc, exp_cw(s, e));
                check("rnd_div", poly_mod(pc, s), 64'd0);
                if (got > 0) check("rnd_period", 64'(cyc - last), 64'(steps[s] + 2));
                last = cyc;
                got++;
            end
            tick();
            cyc++;
            if (pr && iv[s]) begin
                q.push_back(cur);
                sent++;
                if (sent == cnt) iv[s] = 1'b0;
                else begin
                    cur = rnd(s);
                    setmsg(s, cur);
                end
            end
        end
        check("rnd_count", 64'(got), 64'(cnt));
        ordy[s] = 1'b0;
        iv[s] = 1'b0;
    endtask

    logic [63:0] cw, cw_b, hold;
    int lat, bad, n;

    initial begin
        rst = 1'b1; iv = '0; ordy = '0; m0 = '0; m1 = '0; m2 = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", 64'(irdy[0]), 64'd1);
        check("rst_out_valid", 64'(ov[0]), 64'd0);
        check("rst_busy", 64'(bsy[0]), 64'd0);
        check("rst_out_cw", cw_of(0), 64'd0);

        // reset in the middle of a division
        setmsg(0, 64'h00FF_FFFF_FFFF_FFFF);
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (19) tick();
        check("mid_busy", 64'(bsy[0]), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", 64'(irdy[0]), 64'd1);
        check("mid_rst_out_valid", 64'(ov[0]), 64'd0);
        check("mid_rst_busy", 64'(bsy[0]), 64'd0);
        encode(0, 64'd0, cw, lat);
        check("zero_cw", cw, 64'd0);

        encode(0, 64'd1, cw, lat);
        check("unit1_cw", cw, 64'hC5);
        check("unit1_lat", 64'(lat), 64'd56);
        check("unit1_ready_after", 64'(irdy[0]), 64'd1);
        encode(0, 64'd2, cw, lat);
        check("unit2_cw", cw, 64'h14F);
        encode(0, 64'd3, cw, lat);
        check("unit3_cw", cw, 64'h18A);

        encode(1, 64'd1, cw, lat);
        check("w8_unit1_cw", cw, 64'hC5);
        check("w8_unit1_lat", 64'(lat), 64'd7);

        encode(2, 64'd1, cw, lat);
        check("s_unit1_cw", cw, 64'h25);
        check("s_unit1_lat", 64'(lat), 64'd13);
        encode(2, 64'd2, cw, lat);
        check("s_unit2_cw", cw, 64'h4A);

        encode(0, 64'h0055_5555_DDDD_DDDD, cw, lat);
        check("pat_w1_cw", cw, exp_cw(0, 64'h0055_5555_DDDD_DDDD));
        check("pat_w1_lat", 64'(lat), 64'd56);
        encode(1, 64'h0055_5555_DDDD_DDDD, cw_b, lat);
        check("pat_w8_same", cw_b, cw);
        check("pat_w8_lat", 64'(lat), 64'd7);

        // backpressure with a competing message held on the input
        setmsg(0, 64'h0012_3456_789A_BCDE);
        iv[0] = 1'b1;
        tick();
        setmsg(0, 64'h00FE_DCBA_9876_5432);
        n = 0;
        while (!ov[0] && n < 300) begin tick(); n++; end
        check("bp_reach_done", 64'(ov[0]), 64'd1);
        hold = cw_of(0);
        bad = 0;
        repeat (100) begin
            tick();
            if (cw_of(0) !== hold || irdy[0] || !ov[0] || !bsy[0]) bad++;
        end
        check("bp_hold", 64'(bad), 64'd0);
        check("bp_cw", hold, exp_cw(0, 64'h0012_3456_789A_BCDE));
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        iv[0] = 1'b0;
        check("bp_ov_drop", 64'(ov[0]), 64'd0);
        check("bp_ready", 64'(irdy[0]), 64'd1);
        tick();
        check("bp_no_accept", 64'(bsy[0]), 64'd0);

        stream(0, 100);
        stream(1, 200);
        stream(2, 300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
